// File: rtl/access_pkg.sv
// access_pkg: key codes, one-hot state encodings and BCD constants shared by the
// parking access pin entry path. Revision 1.0.
`default_nettype none

package access_pkg;

  localparam int BCD_W = 4;

  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;
  localparam logic [3:0] KEY_BACKSPACE = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_COLLECT = 3'b010,
    ST_PRESENT = 3'b100
  } pin_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pin_entry_collector_if.sv
// pin_entry_collector_if: keypad inputs and PIN valid/ready handshake bundle.
// Revision 1.0.
`default_nettype none

interface pin_entry_collector_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    vehicle_present;
  logic                    pin_ready;
  logic                    pin_valid;
  logic [4*NUM_DIGITS-1:0] pin_value;
  logic [CNT_W-1:0]        digit_count;
  logic                    entry_error;

  // master drives keys and the downstream ready; slave is the collector
  modport master (
    output key_valid, key_code, vehicle_present, pin_ready,
    input  pin_valid, pin_value, digit_count, entry_error
  );

  modport slave (
    input  key_valid, key_code, vehicle_present, pin_ready,
    output pin_valid, pin_value, digit_count, entry_error
  );

endinterface

`default_nettype wire

// File: rtl/pin_entry_collector_timeout_timer.sv
// pin_timeout_timer: saturating idle counter; expired_o flags the last allowed
// idle cycle. Revision 1.0.
`default_nettype none

module pin_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            TW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_q <= count_q + TW'(1);
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/pin_entry_collector.sv
// pin_entry_collector: assembles keypad digits into a packed BCD PIN and offers it
// over valid/ready. Optional PIN_ENTRY_BACKSPACE_EN makes 0xC a backspace. Rev 1.0.
`default_nettype none

module pin_entry_collector
  import access_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  pin_entry_collector_if.slave  bus
);

  localparam int            VW   = BCD_W * NUM_DIGITS;
  localparam int            CW   = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

  pin_state_e    state_q, state_d;
  logic [VW-1:0] value_q, value_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;
  logic          key_accept;
  logic          expired;

  logic digit_key, clear_key, enter_key, bksp_key;

  assign digit_key = bus.key_valid && is_digit(bus.key_code);
  assign clear_key = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign enter_key = bus.key_valid && (bus.key_code == KEY_ENTER);
`ifdef PIN_ENTRY_BACKSPACE_EN
  assign bksp_key  = bus.key_valid && (bus.key_code == KEY_BACKSPACE) && (count_q != '0);
`else
  assign bksp_key  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    count_d    = count_q;
    error_d    = 1'b0;
    key_accept = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.vehicle_present && digit_key) begin
          value_d = VW'(bus.key_code);
          count_d = CW'(1);
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // branch order encodes priority: abort, digit, clear/backspace, enter, timeout
        if (!bus.vehicle_present) begin
          state_d = ST_IDLE;
          value_d = '0;
          count_d = '0;
        end else if (digit_key) begin
          key_accept = 1'b1;
          if (count_q < FULL) begin
            value_d = {value_q[VW-BCD_W-1:0], bus.key_code};
            count_d = count_q + CW'(1);
          end else begin
            error_d = 1'b1;
          end
        end else if (clear_key) begin
          key_accept = 1'b1;
          value_d    = '0;
          count_d    = '0;
        end else if (bksp_key) begin
          key_accept = 1'b1;
          value_d    = value_q >> BCD_W;
          count_d    = count_q - CW'(1);
        end else if (enter_key) begin
          key_accept = 1'b1;
          if (count_q == FULL) begin
            state_d = ST_PRESENT;
          end else begin
            error_d = 1'b1;
            value_d = '0;
            count_d = '0;
            state_d = ST_IDLE;
          end
        end else if (expired) begin
          error_d = 1'b1;
          value_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (bus.pin_ready) begin
          state_d = ST_IDLE;
          value_d = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        value_d = '0;
        count_d = '0;
      end
    endcase
  end

  pin_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (key_accept || (state_q != ST_COLLECT)),
    .enable_i (state_q == ST_COLLECT),
    .expired_o(expired)
  );

  assign bus.pin_valid   = (state_q == ST_PRESENT);
  assign bus.pin_value   = value_q;
  assign bus.digit_count = count_q;
  assign bus.entry_error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_pin_entry_collector.sv
// tb_pin_entry_collector: directed self-checking bench for pin_entry_collector.
// Revision 1.0.
`default_nettype none

module tb_pin_entry_collector;

  localparam int NUM_DIGITS     = 4;
  localparam int TIMEOUT_CYCLES = 20;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  pin_entry_collector_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

  pin_entry_collector #(
    .NUM_DIGITS    (NUM_DIGITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle with the given key strobe; returns at the next falling edge
  task automatic step(input logic kv, input logic [3:0] kc);
    bus.key_valid = kv;
    bus.key_code  = kc;
    @(negedge clock);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.key_valid       = 1'b0;
    bus.key_code        = 4'h0;
    bus.vehicle_present = 1'b0;
    bus.pin_ready       = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_valid", 32'(bus.pin_valid), 32'd0);
    check("rst_value", 32'(bus.pin_value), 32'h0);
    check("rst_count", 32'(bus.digit_count), 32'd0);
    check("rst_error", 32'(bus.entry_error), 32'd0);
    reset = 1'b0;

    // keys ignored without a vehicle
    step(1'b1, 4'h5);
    check("novehicle_count", 32'(bus.digit_count), 32'd0);

    // 2,4,6,8,enter with ready high
    bus.vehicle_present = 1'b1;
    bus.pin_ready       = 1'b1;
    step(1'b1, 4'h2);
    check("first_digit_value", 32'(bus.pin_value), 32'h0002);
    check("first_digit_count", 32'(bus.digit_count), 32'd1);
    step(1'b1, 4'h4);
    step(1'b1, 4'h6);
    step(1'b1, 4'h8);
    check("pre_enter_valid", 32'(bus.pin_valid), 32'd0);
    step(1'b1, 4'hB);
    check("t1_valid", 32'(bus.pin_valid), 32'd1);
    check("t1_value", 32'(bus.pin_value), 32'h2468);
    check("t1_count", 32'(bus.digit_count), 32'd4);
    step(1'b0, 4'h0);
    check("t1_xfer_valid", 32'(bus.pin_valid), 32'd0);
    check("t1_xfer_value", 32'(bus.pin_value), 32'h0);
    check("t1_xfer_count", 32'(bus.digit_count), 32'd0);

    // short entry: 1,2,enter
    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    step(1'b1, 4'hB);
    check("t2_error", 32'(bus.entry_error), 32'd1);
    check("t2_count", 32'(bus.digit_count), 32'd0);
    check("t2_valid", 32'(bus.pin_valid), 32'd0);
    step(1'b1, 4'hB);
    check("t2_error_pulse", 32'(bus.entry_error), 32'd0);
    check("t2_idle_enter", 32'(bus.pin_valid), 32'd0);

    // overflow digit then held presentation
    bus.pin_ready = 1'b0;
    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    step(1'b1, 4'h3);
    step(1'b1, 4'h4);
    check("t3_no_error_yet", 32'(bus.entry_error), 32'd0);
    step(1'b1, 4'h5);
    check("t3_overflow_error", 32'(bus.entry_error), 32'd1);
    check("t3_overflow_value", 32'(bus.pin_value), 32'h1234);
    step(1'b1, 4'hB);
    check("t3_valid", 32'(bus.pin_valid), 32'd1);
    check("t3_error_low", 32'(bus.entry_error), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(i));
      check("t3_hold_valid", 32'(bus.pin_valid), 32'd1);
      check("t3_hold_value", 32'(bus.pin_value), 32'h1234);
    end
    bus.pin_ready = 1'b1;
    step(1'b0, 4'h0);
    check("t3_xfer_valid", 32'(bus.pin_valid), 32'd0);
    check("t3_xfer_count", 32'(bus.digit_count), 32'd0);
    bus.pin_ready = 1'b0;

    // timeout after TIMEOUT_CYCLES idle cycles
    step(1'b1, 4'h7);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step(1'b0, 4'h0);
    check("t4_before_expiry_err", 32'(bus.entry_error), 32'd0);
    check("t4_before_expiry_cnt", 32'(bus.digit_count), 32'd1);
    step(1'b0, 4'h0);
    check("t4_timeout_error", 32'(bus.entry_error), 32'd1);
    check("t4_timeout_count", 32'(bus.digit_count), 32'd0);
    step(1'b0, 4'h0);
    check("t4_timeout_pulse", 32'(bus.entry_error), 32'd0);

    // key in the expiry cycle wins
    step(1'b1, 4'h7);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step(1'b0, 4'h0);
    step(1'b1, 4'h3);
    check("t4b_error", 32'(bus.entry_error), 32'd0);
    check("t4b_count", 32'(bus.digit_count), 32'd2);
    check("t4b_value", 32'(bus.pin_value), 32'h0073);
    step(1'b1, 4'hA);
    check("clear_count", 32'(bus.digit_count), 32'd0);
    check("clear_value", 32'(bus.pin_value), 32'h0);

    // vehicle leaves mid-entry
    step(1'b1, 4'h9);
    step(1'b1, 4'h9);
    check("t5_count", 32'(bus.digit_count), 32'd2);
    bus.vehicle_present = 1'b0;
    step(1'b0, 4'h0);
    check("t5_abort_count", 32'(bus.digit_count), 32'd0);
    check("t5_abort_error", 32'(bus.entry_error), 32'd0);
    bus.vehicle_present = 1'b1;
    step(1'b1, 4'hB);
    check("t5_idle_error", 32'(bus.entry_error), 32'd0);

    // reset while presenting
    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    step(1'b1, 4'h3);
    step(1'b1, 4'h4);
    step(1'b1, 4'hB);
    check("t5_present", 32'(bus.pin_valid), 32'd1);
    reset = 1'b1;
    step(1'b0, 4'h0);
    check("t5_reset_valid", 32'(bus.pin_valid), 32'd0);
    check("t5_reset_value", 32'(bus.pin_value), 32'h0);
    reset = 1'b0;

    // 1,2,0xC,3,4,5,enter
    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    step(1'b1, 4'hC);
`ifdef PIN_ENTRY_BACKSPACE_EN
    check("t6_bksp_value", 32'(bus.pin_value), 32'h0001);
    check("t6_bksp_count", 32'(bus.digit_count), 32'd1);
    step(1'b1, 4'h3);
    step(1'b1, 4'h4);
    step(1'b1, 4'h5);
    check("t6_error", 32'(bus.entry_error), 32'd0);
    step(1'b1, 4'hB);
    check("t6_valid", 32'(bus.pin_valid), 32'd1);
    check("t6_value", 32'(bus.pin_value), 32'h1345);
`else
    check("t6_resv_value", 32'(bus.pin_value), 32'h0012);
    check("t6_resv_count", 32'(bus.digit_count), 32'd2);
    step(1'b1, 4'h3);
    step(1'b1, 4'h4);
    step(1'b1, 4'h5);
    check("t6_error", 32'(bus.entry_error), 32'd1);
    step(1'b1, 4'hB);
    check("t6_valid", 32'(bus.pin_valid), 32'd1);
    check("t6_value", 32'(bus.pin_value), 32'h1234);
`endif
    bus.pin_ready = 1'b1;
    step(1'b0, 4'h0);
    check("t6_xfer_valid", 32'(bus.pin_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pin_entry_collector.md
Name: pin_entry_collector

Overview:
Upstream stage of the parking access controller. Collects keypad digits while a vehicle is at the gate and assembles them into a packed BCD PIN. Presents the PIN to the access FSM over a valid/ready handshake. Handles clear, enter, entry timeout and abort when the vehicle leaves.

Parameters:
NUM_DIGITS, 4, number of BCD digits in a PIN; pin_value width = 4*NUM_DIGITS (16 by default, matching the access FSM key input)
TIMEOUT_CYCLES, 1000, idle clock cycles allowed between accepted keys before the entry is discarded (≥2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
key_valid  in  1  one-cycle strobe per debounced keypress
key_code  in  4  0x0-0x9 digit, 0xA clear, 0xB enter, 0xC-0xF reserved
vehicle_present  in  1  vehicle-arrival sensor level
pin_ready  in  1  downstream accepts the PIN
pin_valid  out  1  PIN available, held until accepted
pin_value  out  4*NUM_DIGITS  packed BCD; first digit in the MS nibble
digit_count  out  $clog2(NUM_DIGITS+1)  digits currently held
entry_error  out  1  one-cycle pulse on rejected entry

Behaviour:
- Reset is synchronous and active-high on clock. All outputs go to 0, the state goes to IDLE and the timer is cleared. A reset in any state, including PRESENT with pin_valid high, drops pin_valid on the next edge.
- States are one-hot: IDLE, COLLECT, PRESENT.
- IDLE:
  - Keys are ignored unless vehicle_present=1.
  - A digit key loads pin_value={0..,digit}, sets digit_count=1, starts the timer and moves to COLLECT.
  - Clear, enter and reserved codes are ignored in IDLE.
- COLLECT, priority order (highest first):
  1. vehicle_present=0: silent abort. Go to IDLE, clear value and count, no error pulse.
  2. key_valid with a digit and count<NUM_DIGITS: pin_value <= {pin_value[4*NUM_DIGITS-5:0], digit}, count+1.
  3. key_valid with a digit and count==NUM_DIGITS: the digit is dropped, value is unchanged and entry_error pulses.
  4. Clear: value=0, count=0, stay in COLLECT.
  5. Enter with count==NUM_DIGITS: go to PRESENT.
  6. Enter with count<NUM_DIGITS: entry_error pulses, value and count are cleared, go to IDLE.
  7. Timer reaches TIMEOUT_CYCLES-1 with no key: entry_error pulses, clear, go to IDLE.
- Every accepted key (digit, clear or enter) restarts the timer to 0. A key in the expiry cycle wins over the timeout. Reserved codes do not restart the timer.
- PRESENT:
  - pin_valid=1 and pin_value/digit_count are held stable. All keys and vehicle_present are ignored.
  - On pin_valid&&pin_ready the transfer occurs. Next cycle: pin_valid=0, value and count=0, state IDLE.
  - pin_valid rises the cycle after the accepting enter; latency from enter strobe to pin_valid is 1 cycle.
- entry_error is registered and is high for exactly one cycle per event.
- Timer width is $clog2(TIMEOUT_CYCLES). The timer runs only in COLLECT and saturates (never wraps).

Optional Feature:
PIN_ENTRY_BACKSPACE_EN
- Defined: code 0xC is backspace in COLLECT.
  - count>0: pin_value <= pin_value>>4, count-1, timer restarted.
  - count==0: ignored, no timer restart.
  - Same priority slot as clear.
- Undefined: 0xC is reserved and ignored like 0xD-0xF.

Decomposition:
- Shared package access_pkg holds:
  - key code constants KEY_CLEAR=4'hA, KEY_ENTER=4'hB, KEY_BACKSPACE=4'hC
  - one-hot state encodings for this block
  - the BCD digit width constant
- One natural sub-module, pin_timeout_timer: clear/enable inputs, saturating count, expired output.

Test Plan:
- vehicle_present=1, keys 2,4,6,8,enter, pin_ready=1 -> pin_valid one cycle after enter, pin_value=16'h2468, digit_count=4, then IDLE.
- Keys 1,2,enter -> entry_error single-cycle pulse, pin_valid stays 0, count=0, state IDLE.
- Keys 1,2,3,4,5,enter -> error pulse on 5, pin_value=16'h1234 presented. With pin_ready=0 for 10 cycles, pin_valid and value are held stable; pin_ready=1 then clears them.
- Key 7, then no keys for TIMEOUT_CYCLES cycles -> entry_error pulse, count=0. Repeat with a key exactly in the expiry cycle -> no error, count=2.
- Keys 9,9 then vehicle_present=0 -> IDLE, no error pulse. Reset asserted while in PRESENT -> pin_valid=0 next edge.
- With PIN_ENTRY_BACKSPACE_EN: keys 1,2,0xC,3,4,5,enter -> pin_value=16'h1345. Without the macro: 0xC ignored, 1,2,3,4 held (5 dropped with error).
